// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller: PC sequencing, outstanding tracking, flush drain
// Optional feature macro: FETCH_PERF_EN (stall/fetch performance counters)
module fetch_ctrl #(
   parameter int branch_addr = 4,
   parameter int MAX_OUT     = 2,
   parameter int STRIDE      = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iq_full,
   input  logic                   iq_empty,
   input  logic                   buffer_full,
   input  logic                   buffer_empty,
   input  logic                   bid_full,
   input  logic                   flush,
   input  logic [branch_addr-1:0] flush_addr,
   output logic                   imem_req,
   output logic [branch_addr-1:0] imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [63:0]            imem_rdata,
   output logic                   iq_push,
   output logic [63:0]            iq_data,
   output logic [branch_addr-1:0] iq_pc,
   output logic [branch_addr-1:0] pc,
   output logic                   busy,
   output logic                   err,
   output logic [15:0]            stall_cnt,
   output logic [15:0]            fetch_cnt
);

   // outstanding/discard count 0..4, PC FIFO pointer wide enough for MAX_OUT entries
   localparam int OW = 3;
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, STALL, DRAIN} state_t;

   state_t                 state;
   logic [branch_addr-1:0] pc_q;
   logic [OW-1:0]          outstanding;
   logic [OW-1:0]          discard;
   logic                   req_q;
   logic                   err_q;
   logic [branch_addr-1:0] pc_fifo [MAX_OUT];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;

   logic                   stall;
   logic                   accept;
   logic                   resp;
   logic                   push;
   logic [OW-1:0]          out_after;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
   endfunction

   // backpressure, handshake qualifiers and the post-cycle outstanding count
   always_comb begin
      stall     = (iq_full | bid_full | buffer_full) & ~(iq_empty & buffer_empty);
      accept    = req_q & imem_gnt;
      resp      = imem_rvalid & (outstanding != '0);
      out_after = outstanding + OW'(accept) - OW'(resp);
      push      = rst & resp & ~flush & ((state == FETCH) | (state == STALL));
   end

   // main controller: state, pc, request, outstanding/discard tracking, FIFO pointers, error flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         pc_q        <= '0;
         outstanding <= '0;
         discard     <= '0;
         req_q       <= 1'b0;
         err_q       <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         if (imem_rvalid && outstanding == '0)
            err_q <= 1'b1;
         case (state)
            IDLE: state <= FETCH;
            default: begin
               if (flush) begin
                  // redirect: anything already in flight (incl. this cycle's grant) is discarded
                  pc_q        <= flush_addr;
                  req_q       <= 1'b0;
                  wr_ptr      <= '0;
                  rd_ptr      <= '0;
                  outstanding <= out_after;
                  discard     <= out_after;
                  state       <= (out_after != '0) ? DRAIN : FETCH;
               end else if (state == DRAIN) begin
                  if (resp) begin
                     outstanding <= outstanding - OW'(1);
                     discard     <= discard - OW'(1);
                     if (discard == OW'(1))
                        state <= FETCH;
                  end
               end else begin
                  if (accept) begin
                     wr_ptr <= next_ptr(wr_ptr);
                     pc_q   <= pc_q + branch_addr'(STRIDE);
                  end
                  if (resp)
                     rd_ptr <= next_ptr(rd_ptr);
                  outstanding <= out_after;
                  if (state == FETCH && stall && !(req_q && !imem_gnt))
                     state <= STALL;
                  else if (state == STALL && !stall)
                     state <= FETCH;
                  // a raised request is held until granted; a new one needs credit and no stall
                  if (req_q && !imem_gnt)
                     req_q <= 1'b1;
                  else
                     req_q <= !stall && (out_after < OW'(MAX_OUT));
               end
            end
         endcase
      end
   end

   // PC FIFO storage: address of each accepted request, in issue order
   always_ff @(posedge clk) begin
      if (rst && !flush && accept && (state == FETCH || state == STALL))
         pc_fifo[wr_ptr] <= pc_q;
   end

`ifdef FETCH_PERF_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] fetch_cnt_q;

   // saturating performance counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         fetch_cnt_q <= '0;
      end else begin
         if (state == STALL && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
         if (accept && fetch_cnt_q != 16'hFFFF)
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fetch_cnt = fetch_cnt_q;
`else
   assign stall_cnt = 16'd0;
   assign fetch_cnt = 16'd0;
`endif

   assign imem_req  = rst & req_q;
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign iq_push   = push;
   assign iq_data   = push ? imem_rdata : 64'd0;
   assign iq_pc     = push ? pc_fifo[rd_ptr] : '0;
   assign busy      = rst & ((state != FETCH) | (outstanding != '0));
   assign err       = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;
   localparam int W       = 4;
   localparam int MAX_OUT = 2;
   localparam int STRIDE  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          iq_full, iq_empty, buffer_full, buffer_empty, bid_full;
   logic          flush;
   logic [W-1:0]  flush_addr;
   logic          imem_req;
   logic [W-1:0]  imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [63:0]   imem_rdata;
   logic          iq_push;
   logic [63:0]   iq_data;
   logic [W-1:0]  iq_pc;
   logic [W-1:0]  pc;
   logic          busy;
   logic          err;
   logic [15:0]   stall_cnt;
   logic [15:0]   fetch_cnt;

   always #5 clk = ~clk;

   fetch_ctrl #(.branch_addr(W), .MAX_OUT(MAX_OUT), .STRIDE(STRIDE)) dut (
      .clk(clk), .rst(rst),
      .iq_full(iq_full), .iq_empty(iq_empty), .buffer_full(buffer_full),
      .buffer_empty(buffer_empty), .bid_full(bid_full),
      .flush(flush), .flush_addr(flush_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .iq_push(iq_push), .iq_data(iq_data), .iq_pc(iq_pc),
      .pc(pc), .busy(busy), .err(err),
      .stall_cnt(stall_cnt), .fetch_cnt(fetch_cnt)
   );

   // every granted fetch the memory still owes a response for; stale = killed by a redirect
   typedef struct {
      logic [W-1:0] addr;
      bit           stale;
   } ent_t;

   ent_t          pend[$];
   int            passed = 0;
   int            fails  = 0;
   int            total  = 0;
   logic [W-1:0]  exp_pc;
   bit            err_exp, idle;
   bit            prev_req, prev_gnt, prev_stall, prev_block;
   logic [W-1:0]  prev_addr;
   int            accepts, pushes, discards;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_stall();
      return (iq_full | bid_full | buffer_full) & ~(iq_empty & buffer_empty);
   endfunction

   task automatic drive(input int p_gnt, input int p_rv, input int p_fl, input int p_st);
      imem_gnt     = ($urandom_range(0, 99) < p_gnt);
      imem_rvalid  = (pend.size() > 0) && ($urandom_range(0, 99) < p_rv);
      imem_rdata   = {$urandom, $urandom};
      flush        = !idle && ($urandom_range(0, 99) < p_fl);
      flush_addr   = W'($urandom_range(0, 15));
      iq_full      = ($urandom_range(0, 99) < p_st);
      bid_full     = ($urandom_range(0, 99) < p_st);
      buffer_full  = ($urandom_range(0, 99) < p_st);
      iq_empty     = ($urandom_range(0, 99) < 30);
      buffer_empty = ($urandom_range(0, 99) < 30);
   endtask

   // check one cycle against the model, then advance to just after the next edge
   task automatic cyc();
      ent_t e;
      bit   exp_push;
      bit   st;
      #2;
      st = model_stall();
      chk("err", 64'(err), 64'(err_exp));
      if (prev_block)
         chk("req_blocked", 64'(imem_req), 64'd0);
      else if (prev_req && !prev_gnt) begin
         chk("req_hold", 64'(imem_req), 64'd1);
         chk("addr_hold", 64'(imem_addr), 64'(prev_addr));
      end else if (imem_req)
         chk("raise_without_stall", 64'(prev_stall), 64'd0);
      if (imem_req)
         chk("req_credit", 64'(pend.size() < MAX_OUT), 64'd1);
      if (pend.size() > 0)
         chk("busy_outstanding", 64'(busy), 64'd1);
      if (imem_rvalid) begin
         if (pend.size() == 0) begin
            chk("stray_push", 64'(iq_push), 64'd0);
            err_exp = 1'b1;
         end else begin
            e = pend.pop_front();
            exp_push = !e.stale && !flush;
            chk("push", 64'(iq_push), 64'(exp_push));
            if (exp_push) begin
               chk("iq_pc", 64'(iq_pc), 64'(e.addr));
               chk("iq_data", iq_data, imem_rdata);
               pushes++;
            end else begin
               chk("iq_data_zero", iq_data, 64'd0);
               discards++;
            end
         end
      end else
         chk("push_quiet", 64'(iq_push), 64'd0);
      if (imem_req && imem_gnt) begin
         chk("imem_addr", 64'(imem_addr), 64'(exp_pc));
         e.addr  = exp_pc;
         e.stale = 1'b0;
         pend.push_back(e);
         exp_pc = W'(exp_pc + STRIDE);
         accepts++;
      end
      if (flush && !idle) begin
         foreach (pend[i]) pend[i].stale = 1'b1;
         exp_pc = flush_addr;
      end
      prev_block = idle || flush;
      prev_req   = imem_req;
      prev_gnt   = imem_gnt;
      prev_stall = st;
      prev_addr  = imem_addr;
      idle       = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      drive(0, 0, 0, 0);
      imem_rvalid = 1'b1;
      imem_rdata  = 64'hDEAD_BEEF_0123_4567;
      repeat (n) begin
         @(posedge clk);
         #3;
         chk("rst_req", 64'(imem_req), 64'd0);
         chk("rst_addr", 64'(imem_addr), 64'd0);
         chk("rst_push", 64'(iq_push), 64'd0);
         chk("rst_data", iq_data, 64'd0);
         chk("rst_iq_pc", 64'(iq_pc), 64'd0);
         chk("rst_pc", 64'(pc), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_err", 64'(err), 64'd0);
         chk("rst_cnt", {32'd0, stall_cnt, fetch_cnt}, 64'd0);
         #(-2 + 2);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(0, 0, 0, 0);
      pend.delete();
      exp_pc     = '0;
      err_exp    = 1'b0;
      idle       = 1'b1;
      prev_block = 1'b1;
      prev_req   = 1'b0;
      prev_gnt   = 1'b0;
      prev_stall = 1'b0;
      accepts    = 0;
   endtask

   initial begin
      int n;
      int a0;
      idle = 1'b1;
      rst  = 1'b0;
      drive(0, 0, 0, 0);
      pushes   = 0;
      discards = 0;
      @(posedge clk);
      #1;
      do_reset(3);

      // free-flowing fetch: grant always, response one cycle later; addresses 0,8,0,8...
      repeat (30) begin drive(100, 100, 0, 0); cyc(); end
      chk("stream_accepts", 64'(accepts >= 25), 64'd1);

      // request raised, grant withheld 3 cycles while iq_full rises: request/address hold
      n = 0;
      while (!imem_req && n < 10) begin drive(0, 100, 0, 0); cyc(); n++; end
      chk("req_seen", 64'(imem_req), 64'd1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 100, 0, 0);
         iq_full = 1'b1; iq_empty = 1'b0; buffer_empty = 1'b0;
         cyc();
      end
      drive(100, 100, 0, 0);
      iq_full = 1'b1; iq_empty = 1'b0; buffer_empty = 1'b0;
      cyc();
      for (int i = 0; i < 4; i++) begin
         drive(100, 100, 0, 0);
         iq_full = 1'b1; iq_empty = 1'b0; buffer_empty = 1'b0;
         chk("stall_no_req", 64'(imem_req), 64'd0);
         chk("stall_busy", 64'(busy), 64'd1);
         cyc();
      end

      // full flags with both queues empty do not stall
      a0 = accepts;
      for (int i = 0; i < 20; i++) begin
         drive(100, 100, 0, 0);
         iq_full = 1'b1; iq_empty = 1'b1; buffer_empty = 1'b1;
         cyc();
      end
      chk("empty_override_fetch", 64'(accepts - a0 > 10), 64'd1);

      // randomized traffic with stalls and flushes
      repeat (3000) begin drive(60, 50, 5, 30); cyc(); end
      chk("saw_pushes", 64'(pushes > 100), 64'd1);
      chk("saw_discards", 64'(discards > 0), 64'd1);
`ifdef FETCH_PERF_EN
      chk("fetch_cnt", 64'(fetch_cnt), 64'(accepts > 65535 ? 65535 : accepts));
`else
      chk("perf_off", {32'd0, stall_cnt, fetch_cnt}, 64'd0);
`endif

      // two outstanding, flush to 4: both responses discarded, then fetch resumes at 4
      n = 0;
      while (pend.size() < 2 && n < 20) begin drive(100, 0, 0, 0); cyc(); n++; end
      chk("two_outstanding", 64'(pend.size()), 64'd2);
      drive(0, 0, 0, 0); flush = 1'b1; flush_addr = W'(4);
      cyc();
      n = 0;
      while (pend.size() > 0 && n < 20) begin drive(0, 100, 0, 0); cyc(); n++; end
      chk("drain_done", 64'(pend.size()), 64'd0);
      n = 0;
      while (!(imem_req && imem_gnt) && n < 20) begin
         drive(100, 0, 0, 0);
         if (imem_req) chk("redirect_addr", 64'(imem_addr), 64'd4);
         cyc();
         n++;
      end
      chk("redirect_fetched", 64'(n < 20), 64'd1);

      // flush together with the only response: no drain, straight back to fetching
      n = 0;
      while (pend.size() > 0 && n < 20) begin drive(0, 100, 0, 0); cyc(); n++; end
      n = 0;
      while (pend.size() != 1 && n < 20) begin drive(100, 0, 0, 0); cyc(); n++; end
      chk("one_outstanding", 64'(pend.size()), 64'd1);
      drive(0, 100, 0, 0); flush = 1'b1; flush_addr = W'(4);
      chk("flush_with_rvalid", 64'(imem_rvalid), 64'd1);
      cyc();
      drive(0, 0, 0, 0);
      chk("no_drain_busy", 64'(busy), 64'd0);
      chk("flush_pc", 64'(pc), 64'd4);
      cyc();

`ifdef FETCH_PERF_EN
      // five cycles parked in STALL
      do_reset(1);
      for (int i = 0; i < 7; i++) begin
         drive(0, 0, 0, 0);
         iq_full = 1'b1; iq_empty = 1'b0; buffer_empty = 1'b0;
         cyc();
      end
      chk("stall_cnt", 64'(stall_cnt), 64'd5);
`endif

      // reset with requests in flight, then a stray response sets the sticky error
      repeat (4) begin drive(100, 0, 0, 0); cyc(); end
      do_reset(2);
      drive(0, 0, 0, 0);
      imem_rvalid = 1'b1;
      cyc();
      repeat (4) begin drive(0, 0, 0, 0); cyc(); end
      chk("err_sticky", 64'(err), 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // hard ceiling in case a DUT event never arrives
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
